// File: rtl/bp_be_regfile_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bp_be_regfile_wb_sequencer
//  Description : Merges two in-order writeback lanes into one shared FIFO and
//                drains one entry per cycle onto the single regfile write
//                port. Publishes a per-register pending mask for issue stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_be_regfile_wb_sequencer #(
  parameter  int data_width_p     = 64,
  parameter  int reg_addr_width_p = 5,
  parameter  int fifo_els_p       = 4,
  parameter  int zero_x0_p        = 1,
  localparam int regs_lp          = 2 ** reg_addr_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        wb0_v_i,
  input  logic [reg_addr_width_p-1:0] wb0_addr_i,
  input  logic [data_width_p-1:0]     wb0_data_i,
  output logic                        wb0_ready_o,
  input  logic                        wb1_v_i,
  input  logic [reg_addr_width_p-1:0] wb1_addr_i,
  input  logic [data_width_p-1:0]     wb1_data_i,
  output logic                        wb1_ready_o,
  output logic                        rd_w_v_o,
  output logic [reg_addr_width_p-1:0] rd_addr_o,
  output logic [data_width_p-1:0]     rd_data_o,
  output logic [regs_lp-1:0]          pending_o,
  output logic                        empty_o
);

  localparam int c_ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int c_cnt_w = $clog2(fifo_els_p + 1);
  localparam logic [c_cnt_w-1:0] c_els_m1 = c_cnt_w'(fifo_els_p - 1);
  localparam logic [c_cnt_w-1:0] c_els_m2 = c_cnt_w'(fifo_els_p - 2);
  localparam bit c_params_ok = (fifo_els_p >= 2) && ((fifo_els_p & (fifo_els_p - 1)) == 0);

  logic [reg_addr_width_p-1:0] r_addr_mem [fifo_els_p];
  logic [data_width_p-1:0]     r_data_mem [fifo_els_p];
  logic [c_ptr_w-1:0]          r_rd_ptr;
  logic [c_ptr_w-1:0]          r_wr_ptr;
  logic [c_cnt_w-1:0]          r_count;

  logic               w_ready0;
  logic               w_ready1;
  logic               w_drop0;
  logic               w_drop1;
  logic               w_enq0;
  logic               w_enq1;
  logic               w_deq;
  logic [c_cnt_w-1:0] w_enq_cnt;
  logic [c_ptr_w-1:0] w_wr_idx1;
  logic [regs_lp-1:0] w_pending;

  // Readiness is taken from the registered count only; lane 1 is refused
  // whenever a valid lane 0 is refused so program order is never inverted.
  assign w_ready0 = reset_n_i & (r_count <= c_els_m1);
  assign w_ready1 = reset_n_i & (wb0_v_i ? (w_ready0 & (r_count <= c_els_m2))
                                         : (r_count <= c_els_m1));

  // x0 writes on the integer file complete the handshake but occupy no slot.
  assign w_drop0 = (zero_x0_p != 0) && (wb0_addr_i == '0);
  assign w_drop1 = (zero_x0_p != 0) && (wb1_addr_i == '0);
  assign w_enq0  = wb0_v_i & w_ready0 & ~w_drop0;
  assign w_enq1  = wb1_v_i & w_ready1 & ~w_drop1;

  // Lane 1 packs directly behind lane 0, or takes the tail slot if lane 0 did not enqueue.
  assign w_wr_idx1 = r_wr_ptr + c_ptr_w'(w_enq0);
  assign w_enq_cnt = c_cnt_w'(w_enq0) + c_cnt_w'(w_enq1);
  assign w_deq     = (r_count != '0);

  // Pointer and occupancy bookkeeping; queued writes are discarded on reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + c_ptr_w'(w_deq);
      r_wr_ptr <= r_wr_ptr + c_ptr_w'(w_enq_cnt);
      r_count  <= r_count + w_enq_cnt - c_cnt_w'(w_deq);
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_enq0) begin
      r_addr_mem[r_wr_ptr] <= wb0_addr_i;
      r_data_mem[r_wr_ptr] <= wb0_data_i;
    end
    if (w_enq1) begin
      r_addr_mem[w_wr_idx1] <= wb1_addr_i;
      r_data_mem[w_wr_idx1] <= wb1_data_i;
    end
  end

  // An entry is occupied when its distance from the head is below the count.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < fifo_els_p; i++) begin
      if (c_cnt_w'(c_ptr_w'(i) - r_rd_ptr) < r_count) begin
        w_pending[r_addr_mem[i]] = 1'b1;
      end
    end
    if (zero_x0_p != 0) begin
      w_pending[0] = 1'b0;
    end
  end

  assign wb0_ready_o = w_ready0;
  assign wb1_ready_o = w_ready1;
  assign rd_w_v_o    = w_deq;
  assign rd_addr_o   = r_addr_mem[r_rd_ptr];
  assign rd_data_o   = r_data_mem[r_rd_ptr];
  assign pending_o   = w_pending;
  assign empty_o     = (r_count == '0);

`ifndef SYNTHESIS
  logic [c_cnt_w:0] w_count_sum;
  assign w_count_sum = {1'b0, r_count} + (c_cnt_w + 1)'(w_enq_cnt);

  a_params_ok: assert property (@(posedge clk_i) c_params_ok);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    w_count_sum <= (c_cnt_w + 1)'(fifo_els_p) + (c_cnt_w + 1)'(w_deq));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (w_count_sum >= (c_cnt_w + 1)'(w_deq)) && (r_count <= c_cnt_w'(fifo_els_p)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_be_regfile_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bp_be_regfile_wb_sequencer
//  Description : Scoreboard bench for the writeback sequencer. Stimulus pushes
//                expected regfile writes; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_be_regfile_wb_sequencer;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb0_v = 1'b0, wb1_v = 1'b0;
  logic [4:0]  wb0_addr = '0, wb1_addr = '0;
  logic [63:0] wb0_data = '0, wb1_data = '0;
  logic        wb0_ready, wb1_ready, rd_w_v, empty;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic [31:0] pending;

  logic        fp_wb0_v = 1'b0;
  logic [4:0]  fp_wb0_addr = '0;
  logic [63:0] fp_wb0_data = '0;
  logic        fp_wb1_v = 1'b0;
  logic [4:0]  fp_wb1_addr = '0;
  logic [63:0] fp_wb1_data = '0;
  logic        fp_wb0_ready, fp_wb1_ready, fp_rd_w_v, fp_empty;
  logic [4:0]  fp_rd_addr;
  logic [63:0] fp_rd_data;
  logic [31:0] fp_pending;

  int  total = 0;
  int  bad = 0;
  int  m_count = 0;
  sb_t sb[$];

  bp_be_regfile_wb_sequencer #(.zero_x0_p(1)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .wb0_v_i(wb0_v), .wb0_addr_i(wb0_addr), .wb0_data_i(wb0_data), .wb0_ready_o(wb0_ready),
    .wb1_v_i(wb1_v), .wb1_addr_i(wb1_addr), .wb1_data_i(wb1_data), .wb1_ready_o(wb1_ready),
    .rd_w_v_o(rd_w_v), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
    .pending_o(pending), .empty_o(empty)
  );

  bp_be_regfile_wb_sequencer #(.zero_x0_p(0)) dut_fp (
    .clk_i(clk), .reset_n_i(rst_n),
    .wb0_v_i(fp_wb0_v), .wb0_addr_i(fp_wb0_addr), .wb0_data_i(fp_wb0_data), .wb0_ready_o(fp_wb0_ready),
    .wb1_v_i(fp_wb1_v), .wb1_addr_i(fp_wb1_addr), .wb1_data_i(fp_wb1_data), .wb1_ready_o(fp_wb1_ready),
    .rd_w_v_o(fp_rd_w_v), .rd_addr_o(fp_rd_addr), .rd_data_o(fp_rd_data),
    .pending_o(fp_pending), .empty_o(fp_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      check("pending_bit0", 64'(pending[0]), 64'd0);
      if (rd_w_v) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: actual addr=%0d data=%0h expected no write", rd_addr, rd_data);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("wr_addr", 64'(rd_addr), 64'(e.addr));
          check("wr_data", rd_data, e.data);
          check("wr_pending", 64'(pending[rd_addr]), 64'd1);
        end
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic drive(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                       output logic acc0, output logic acc1);
    logic er0, er1;
    sb_t  e;
    int   enq;
    wb0_v = v0; wb0_addr = a0; wb0_data = d0;
    wb1_v = v1; wb1_addr = a1; wb1_data = d1;
    #1;
    er0 = (m_count <= 3);
    er1 = v0 ? (er0 && (m_count <= 2)) : (m_count <= 3);
    check("wb0_ready", 64'(wb0_ready), 64'(er0));
    check("wb1_ready", 64'(wb1_ready), 64'(er1));
    check("empty", 64'(empty), 64'(m_count == 0));
    check("rd_w_v", 64'(rd_w_v), 64'(m_count != 0));
    acc0 = v0 & er0;
    acc1 = v1 & er1;
    enq = 0;
    if (acc0 && a0 != 5'd0) begin e.addr = a0; e.data = d0; sb.push_back(e); enq++; end
    if (acc1 && a1 != 5'd0) begin e.addr = a1; e.data = d1; sb.push_back(e); enq++; end
    m_count = m_count + enq - ((m_count != 0) ? 1 : 0);
    @(posedge clk);
    #1;
    wb0_v = 1'b0;
    wb1_v = 1'b0;
  endtask

  task automatic idle();
    logic x0, x1;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, x0, x1);
  endtask

  task automatic drain();
    int g = 0;
    while (m_count != 0 && g < 20) begin
      idle();
      g++;
    end
    check("drain_empty", 64'(empty), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // Presents an in-order stream, re-offering refused writes on lane 0 next cycle.
  task automatic stream(input int n, input int base, input bit rand1);
    sb_t  items[$];
    sb_t  e, e1;
    logic acc0, acc1, v1;
    int   guard = 0;
    for (int i = 0; i < n; i++) begin
      e.addr = 5'(1 + ((base + i) % 31));
      e.data = 64'h0000_5EED_0000_0000 + 64'(base + i);
      items.push_back(e);
    end
    while (items.size() > 0) begin
      if (guard >= 200) begin
        total++;
        bad++;
        $display("FAIL stream_timeout: actual remaining=%0d expected 0", items.size());
        break;
      end
      v1 = (items.size() > 1) && (!rand1 || ($urandom_range(0, 1) == 1));
      e1 = (items.size() > 1) ? items[1] : items[0];
      drive(1'b1, items[0].addr, items[0].data, v1, e1.addr, e1.data, acc0, acc1);
      if (acc0) void'(items.pop_front());
      if (acc1) void'(items.pop_front());
      guard++;
    end
  endtask

  initial begin
    logic a0, a1;

    // Reset state
    #2;
    check("rst_wb0_ready", 64'(wb0_ready), 64'd0);
    check("rst_wb1_ready", 64'(wb1_ready), 64'd0);
    check("rst_rd_w_v", 64'(rd_w_v), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write latency and pending window
    drive(1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'd0, a0, a1);
    check("t1_pending_n1", 64'(pending), 64'h20);
    idle();
    check("t1_rd_w_v_n2", 64'(rd_w_v), 64'd0);
    check("t1_pending_n2", 64'(pending), 64'd0);
    check("t1_empty_n2", 64'(empty), 64'd1);

    // Same address on both lanes: lane 0 first, lane 1 last
    drive(1'b1, 5'd3, 64'h1, 1'b1, 5'd3, 64'h2, a0, a1);
    check("t2_pending_n1", 64'(pending), 64'h8);
    idle();
    check("t2_pending_n2", 64'(pending), 64'h8);
    idle();
    check("t2_pending_n3", 64'(pending), 64'd0);

    // Both lanes saturated, addresses 1..12
    stream(12, 0, 1'b0);
    drain();

    // x0 dropped on the integer file, kept on the FP file
    drive(1'b1, 5'd0, 64'hDEAD, 1'b1, 5'd7, 64'h77, a0, a1);
    check("t4_acc0", 64'(a0), 64'd1);
    check("t4_acc1", 64'(a1), 64'd1);
    check("t4_pending", 64'(pending), 64'h80);
    idle();
    check("t4_empty", 64'(empty), 64'd1);
    fp_wb0_v = 1'b1; fp_wb0_addr = 5'd0; fp_wb0_data = 64'h99;
    #1;
    check("t4_fp_ready", 64'(fp_wb0_ready), 64'd1);
    @(posedge clk); #1;
    fp_wb0_v = 1'b0;
    check("t4_fp_rd_w_v", 64'(fp_rd_w_v), 64'd1);
    check("t4_fp_rd_addr", 64'(fp_rd_addr), 64'd0);
    check("t4_fp_rd_data", fp_rd_data, 64'h99);
    check("t4_fp_pending", 64'(fp_pending), 64'h1);
    @(posedge clk); #1;
    check("t4_fp_empty", 64'(fp_empty), 64'd1);

    // Asynchronous reset with three entries queued
    drive(1'b1, 5'd10, 64'h10, 1'b1, 5'd11, 64'h11, a0, a1);
    drive(1'b1, 5'd12, 64'h12, 1'b1, 5'd13, 64'h13, a0, a1);
    check("t5_pending_pre", 64'(pending), 64'h0000_3800);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rd_w_v", 64'(rd_w_v), 64'd0);
    check("t5_pending", 64'(pending), 64'd0);
    check("t5_empty", 64'(empty), 64'd1);
    check("t5_wb0_ready", 64'(wb0_ready), 64'd0);
    sb.delete();
    m_count = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 5'd9, 64'h55, 1'b0, 5'd0, 64'd0, a0, a1);
    check("t5_pending_9", 64'(pending), 64'h200);
    drain();

    // Long stream with random lane-1 gaps, several pointer wraps
    stream(20, 40, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
